sha256_mem_responder: RTL and testbench

SHA256_MEM_RESPONDER -- requirements
Module: sha256_mem_responder

---
 rtl/sha256_mem_pkg.sv | 23 ++
 rtl/sha256_ram.sv | 67 ++++++
 rtl/sha256_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_sha256_mem_responder.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_mem_pkg.sv
// Shared types and constants for the SHA-256 memory responder.
// Holds the FSM state enum, digest geometry and an address range helper.
package sha256_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DIGEST_WORDS  = 8;
    localparam int DEFAULT_DEPTH = 1024;
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 32;

    // True when a 16-bit word address falls inside a memory of `depth` words.
    function automatic logic in_range(
        input logic [ADDR_W-1:0] addr,
        input int                depth
    );
        return {16'd0, addr} < 32'(depth);
    endfunction

endpackage

// File: rtl/sha256_ram.sv
// DEPTH x 32 word memory: one write port, two registered read ports.
// Ports: we/waddr/wdata (write), eng_raddr -> eng_rdata (read every cycle),
//        host_re/host_raddr -> host_rdata (read on host_re, held otherwise).
// Reads return the pre-write contents on a same-edge collision; addresses
// >= DEPTH read as zero and are never written. Contents are not reset.
module sha256_ram
    import sha256_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] eng_raddr,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              host_re,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [DATA_W-1:0] host_rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] eng_rdata_q, eng_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    // Storage array: no reset, write dropped when out of range.
    always_ff @(posedge clk) begin
        if (we && in_range(waddr, DEPTH)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        eng_rdata_d = '0;
        if (in_range(eng_raddr, DEPTH)) begin
            eng_rdata_d = mem[eng_raddr[IDX_W-1:0]];
        end
    end

    always_comb begin
        host_rdata_d = host_rdata_q;
        if (host_re) begin
            host_rdata_d = '0;
            if (in_range(host_raddr, DEPTH)) begin
                host_rdata_d = mem[host_raddr[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            eng_rdata_q  <= eng_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign eng_rdata  = eng_rdata_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory responder shared by a SHA-256 engine and a host, with digest capture.
// Ports: clk, reset_n; engine mem_we/mem_addr/mem_write_data/mem_read_data;
//        eng_start/eng_done/output_addr; host_req/host_we/host_addr/
//        host_wdata -> host_ack/host_rdata; digest, digest_valid, busy.
// Optional: define SHA_MEM_RANGE_CHECK_EN to add the sticky err_oob output.
module sha256_mem_responder
    import sha256_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_write_data,
    output logic [DATA_W-1:0]          mem_read_data,
    input  logic                       eng_start,
    input  logic                       eng_done,
    input  logic [ADDR_W-1:0]          output_addr,
    input  logic                       host_req,
    input  logic                       host_we,
    input  logic [ADDR_W-1:0]          host_addr,
    input  logic [DATA_W-1:0]          host_wdata,
    output logic                       host_ack,
    output logic [DATA_W-1:0]          host_rdata,
    output logic [DIGEST_WORDS*32-1:0] digest,
    output logic                       digest_valid,
    output logic                       busy
`ifdef SHA_MEM_RANGE_CHECK_EN
   ,output logic                       err_oob
`endif
);

    localparam logic [2:0]        LAST_W = 3'(DIGEST_WORDS - 1);
    localparam logic [ADDR_W-1:0] NWORDS = ADDR_W'(DIGEST_WORDS);

    state_e state_q, state_d;

    logic start_acc;
    logic host_go;
    logic host_wr;

    logic                   host_ack_q, host_ack_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [DIGEST_WORDS-1:0][DATA_W-1:0] digest_q, digest_d;
    logic [DIGEST_WORDS-1:0] mask_q, mask_d;
    logic                   valid_q, valid_d;

    logic [ADDR_W-1:0] offset;
    logic [2:0]        word_k;
    logic              cap_hit;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (eng_start) state_d = ST_RUN;
            ST_RUN:  if (eng_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = 1'b0;
        start_acc = 1'b0;
        if (state_q == ST_RUN) begin
            busy = 1'b1;
        end else begin
            start_acc = eng_start;
        end
    end

    // Host is served in IDLE only, never in a start cycle, never in the
    // ack cycle (forces a gap between back-to-back accesses), and waits
    // while the engine occupies the single write port.
    always_comb begin
        host_go = (state_q == ST_IDLE) && !eng_start && host_req
                  && !host_ack_q && !(host_we && mem_we);
        host_wr = host_go && host_we;
        host_ack_d = host_go;
    end

    // Write port arbitration: engine first.
    always_comb begin
        ram_we    = mem_we | host_wr;
        ram_waddr = mem_we ? mem_addr       : host_addr;
        ram_wdata = mem_we ? mem_write_data : host_wdata;
    end

    sha256_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (ram_we),
        .waddr      (ram_waddr),
        .wdata      (ram_wdata),
        .eng_raddr  (mem_addr),
        .eng_rdata  (mem_read_data),
        .host_re    (host_go),
        .host_raddr (host_addr),
        .host_rdata (host_rdata)
    );

    // Digest capture window: offset is taken modulo 2^16 so a base near
    // the top of the address space wraps around to low addresses.
    always_comb begin
        offset  = mem_addr - base_q;
        word_k  = offset[2:0];
        cap_hit = (state_q == ST_RUN) && mem_we && (offset < NWORDS);
    end

    always_comb begin
        base_d   = base_q;
        digest_d = digest_q;
        mask_d   = mask_q;
        if (start_acc) begin
            base_d   = output_addr;
            digest_d = '0;
            mask_d   = '0;
        end else if (cap_hit) begin
            // Word 0 sits in the top slice of the packed digest.
            digest_d[LAST_W - word_k] = mem_write_data;
            mask_d[word_k]            = 1'b1;
        end
        valid_d = start_acc ? 1'b0 : (valid_q | (&mask_d));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_ack_q <= 1'b0;
            base_q     <= '0;
            digest_q   <= '0;
            mask_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            host_ack_q <= host_ack_d;
            base_q     <= base_d;
            digest_q   <= digest_d;
            mask_q     <= mask_d;
            valid_q    <= valid_d;
        end
    end

    assign host_ack     = host_ack_q;
    assign digest       = digest_q;
    assign digest_valid = valid_q;

`ifdef SHA_MEM_RANGE_CHECK_EN
    logic err_q, err_d;
    logic oob_hit;

    // The engine port reads every cycle, so its address always counts.
    always_comb begin
        oob_hit = !in_range(mem_addr, DEPTH)
                  || (host_go && !in_range(host_addr, DEPTH));
        err_d   = start_acc ? 1'b0 : (err_q | oob_hit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_oob = err_q;
`endif

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed self-checking bench for sha256_mem_responder.
// Covers host/engine access, digest capture, arbitration, range and reset.
module tb_sha256_mem_responder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic         eng_start;
    logic         eng_done;
    logic [15:0]  output_addr;
    logic         host_req;
    logic         host_we;
    logic [15:0]  host_addr;
    logic [31:0]  host_wdata;
    logic         host_ack;
    logic [31:0]  host_rdata;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
`ifdef SHA_MEM_RANGE_CHECK_EN
    logic         err_oob;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic [31:0] dw [8] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };

    always #5 clk = ~clk;

    sha256_mem_responder #(
        .DEPTH (1024)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .eng_start      (eng_start),
        .eng_done       (eng_done),
        .output_addr    (output_addr),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rdata     (host_rdata),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .busy           (busy)
`ifdef SHA_MEM_RANGE_CHECK_EN
       ,.err_oob        (err_oob)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one host access and waits (bounded) for its ack.
    task automatic host_op(
        input  logic        we,
        input  logic [15:0] a,
        input  logic [31:0] d,
        output logic        seen,
        output logic [31:0] rd
    );
        seen = 1'b0;
        rd   = '0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        for (int i = 0; i < 4 && !seen; i++) begin
            step();
            if (host_ack === 1'b1) begin
                seen = 1'b1;
                rd   = host_rdata;
            end
        end
        host_req = 1'b0;
        host_we  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mem_we = 0; mem_addr = 0; mem_write_data = 0;
        eng_start = 0; eng_done = 0; output_addr = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (3) step();
        checks++;
        if ({busy, host_ack, digest_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000",
                     {busy, host_ack, digest_valid});
        end
        checks++;
        if (mem_read_data !== 32'h0 || host_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h/%h exp=0/0",
                     mem_read_data, host_rdata);
        end
        checks++;
        if (digest !== 256'h0) begin
            failures++;
            $display("FAIL reset_digest got=%h exp=0", digest);
        end
`ifdef SHA_MEM_RANGE_CHECK_EN
        checks++;
        if (err_oob !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err_oob);
        end
`endif
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_host_rw();
        logic seen;
        logic [31:0] rd;
        host_op(1'b1, 16'h0000, 32'h61626380, seen, rd);
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL host_wr_ack got=%b exp=1", seen);
        end
        host_op(1'b0, 16'h0000, 32'h0, seen, rd);
        checks++;
        if (seen !== 1'b1 || rd !== 32'h61626380) begin
            failures++;
            $display("FAIL host_rd got=%b/%h exp=1/61626380", seen, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step();
            acks[3-i] = host_ack;
        end
        host_req = 1'b0;
        step();
        checks++;
        if (acks !== 4'b1010) begin
            failures++;
            $display("FAIL host_b2b_acks got=%b exp=1010", acks);
        end
    endtask

    task automatic test_engine_rw();
        mem_addr = 16'h0000; mem_we = 1'b0;
        step();
        checks++;
        if (mem_read_data !== 32'h61626380) begin
            failures++;
            $display("FAIL eng_rd got=%h exp=61626380", mem_read_data);
        end
        mem_we = 1'b1; mem_write_data = 32'h0;
        step();
        checks++;
        if (mem_read_data !== 32'h61626380) begin
            failures++;
            $display("FAIL eng_rd_old got=%h exp=61626380", mem_read_data);
        end
        mem_we = 1'b0;
        step();
        checks++;
        if (mem_read_data !== 32'h0) begin
            failures++;
            $display("FAIL eng_rd_new got=%h exp=0", mem_read_data);
        end
    endtask

    task automatic test_digest();
        output_addr = 16'h0100; eng_start = 1'b1;
        step();
        eng_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || digest_valid !== 1'b0) begin
            failures++;
            $display("FAIL dig_start got=%b%b exp=10", busy, digest_valid);
        end
        for (int k = 7; k >= 0; k--) begin
            mem_we = 1'b1;
            mem_addr = 16'h0100 + 16'(k);
            mem_write_data = dw[k];
            step();
            if (k == 1) begin
                checks++;
                if (digest_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL dig_early got=%b exp=0", digest_valid);
                end
            end
        end
        checks++;
        if (digest_valid !== 1'b1 || digest !== ABC_DIGEST) begin
            failures++;
            $display("FAIL dig_full got=%b/%h exp=1/%h",
                     digest_valid, digest, ABC_DIGEST);
        end
        mem_addr = 16'h0103; mem_write_data = 32'hdeadbeef;
        step();
        checks++;
        if (digest[159:128] !== 32'hdeadbeef || digest_valid !== 1'b1) begin
            failures++;
            $display("FAIL dig_rewrite got=%h/%b exp=deadbeef/1",
                     digest[159:128], digest_valid);
        end
        mem_write_data = dw[3];
        step();
        mem_we = 1'b0; mem_addr = 16'h0000;
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || digest_valid !== 1'b1) begin
            failures++;
            $display("FAIL dig_done got=%b%b exp=01", busy, digest_valid);
        end
    endtask

    task automatic test_start_priority();
        logic seen;
        int   early;
        early = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0100;
        output_addr = 16'h0100; eng_start = 1'b1;
        step();
        eng_start = 1'b0;
        if (host_ack !== 1'b0) early++;
        repeat (3) begin
            step();
            if (host_ack !== 1'b0) early++;
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        if (host_ack !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL prio_no_ack got=%0d exp=0 acks in RUN", early);
        end
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step();
            if (host_ack === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (host_rdata !== 32'hba7816bf) begin
                    failures++;
                    $display("FAIL prio_rdata got=%h exp=ba7816bf",
                             host_rdata);
                end
            end
        end
        host_req = 1'b0;
        step();
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL prio_ack_late got=%b exp=1", seen);
        end
    endtask

    task automatic test_oob();
        logic seen;
        logic [31:0] rd;
        mem_we = 1'b1; mem_addr = 16'd1024; mem_write_data = 32'h12345678;
        step();
        mem_we = 1'b0;
        step();
        checks++;
        if (mem_read_data !== 32'h0) begin
            failures++;
            $display("FAIL oob_eng_rd got=%h exp=0", mem_read_data);
        end
`ifdef SHA_MEM_RANGE_CHECK_EN
        checks++;
        if (err_oob !== 1'b1) begin
            failures++;
            $display("FAIL oob_err_set got=%b exp=1", err_oob);
        end
`endif
        mem_addr = 16'h0000;
        host_op(1'b0, 16'h0000, 32'h0, seen, rd);
        checks++;
        if (seen !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL oob_alias got=%b/%h exp=1/0", seen, rd);
        end
        host_op(1'b0, 16'd1024, 32'h0, seen, rd);
        checks++;
        if (seen !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL oob_host_rd got=%b/%h exp=1/0", seen, rd);
        end
`ifdef SHA_MEM_RANGE_CHECK_EN
        output_addr = 16'h0300; eng_start = 1'b1;
        step();
        eng_start = 1'b0;
        checks++;
        if (err_oob !== 1'b0) begin
            failures++;
            $display("FAIL oob_err_clr got=%b exp=0", err_oob);
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        step();
`endif
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        logic [31:0] rd;
        output_addr = 16'h0200; eng_start = 1'b1;
        step();
        eng_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_we = 1'b1;
            mem_addr = 16'h0200 + 16'(k);
            mem_write_data = 32'h1000_0000 + 32'(k);
            step();
        end
        mem_we = 1'b0; mem_addr = 16'h0000;
        checks++;
        if (digest[255:224] !== 32'h10000000 || digest_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre got=%h/%b exp=10000000/0",
                     digest[255:224], digest_valid);
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0202;
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, digest_valid, host_ack} !== 3'b000
            || digest !== 256'h0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%h exp=000/0",
                     {busy, digest_valid, host_ack}, digest);
        end
        host_req = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        host_op(1'b0, 16'h0202, 32'h0, seen, rd);
        checks++;
        if (seen !== 1'b1 || rd !== 32'h10000002) begin
            failures++;
            $display("FAIL rst_mem_keep got=%b/%h exp=1/10000002", seen, rd);
        end
        host_op(1'b0, 16'h0107, 32'h0, seen, rd);
        checks++;
        if (seen !== 1'b1 || rd !== 32'hf20015ad) begin
            failures++;
            $display("FAIL rst_mem_dig got=%b/%h exp=1/f20015ad", seen, rd);
        end
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_back_to_back();
        test_engine_rw();
        test_digest();
        test_start_priority();
        test_oob();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
